// File: rtl/uart_rx_core.sv
// UART receive front end: 16x oversampling, start validation,
// LSB-first data shift, optional parity and stop check with FE/PE/OE flags.
module uart_rx_core #(
    parameter int BAUD_DIV   = 27,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 rxd,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 ready,
    output logic                 FE,
    output logic                 PE,
    output logic                 OE,
    output logic                 busy
);

    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(BAUD_DIV - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
    } state_t;

    state_t state, state_nx;

    logic                 rx_meta, rxs;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [3:0]           sample_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_pending;
    logic                 start_entry, bit_end, mid_start;
    logic                 data_smp, par_smp, stop_smp, ferr_now;

    assign tick = (tick_cnt == TICK_MAX);

    // two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // free-running oversample tick, re-phased at each start edge
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            tick_cnt <= '0;
        else if (start_entry || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    // FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (!rxs) state_nx = START;
            START:     if (mid_start) state_nx = rxs ? IDLE : DATA;
            DATA:      if (data_smp && bit_cnt == LAST_BIT)
                           state_nx = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:    if (par_smp) state_nx = STOP;
            STOP:      if (stop_smp) state_nx = rxs ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rxs) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // FSM output strobes: sampling points within each bit
    always_comb begin
        start_entry = (state == IDLE) && !rxs;
        bit_end     = tick && (sample_cnt == 4'd15);
        mid_start   = (state == START) && tick && (sample_cnt == 4'd7);
        data_smp    = (state == DATA) && bit_end;
        par_smp     = (state == PARITY) && bit_end;
        stop_smp    = (state == STOP) && bit_end;
        ferr_now    = stop_smp && !rxs;
    end

    // tick-within-bit and data-bit counters, restarted on every transition
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
        end else if (state_nx != state) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
        end else begin
            if (tick)
                sample_cnt <= sample_cnt + 4'd1;
            if (data_smp)
                bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // shift register and parity check
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shreg        <= '0;
            perr_pending <= 1'b0;
        end else begin
            if (start_entry)
                perr_pending <= 1'b0;
            if (data_smp)
                shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (par_smp)
                perr_pending <= ^{shreg, rxs, 1'(PARITY_ODD)};
        end
    end

    // receive data register and status flags; completion beats rd
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rx_data <= '0;
            ready   <= 1'b0;
            FE      <= 1'b0;
            PE      <= 1'b0;
            OE      <= 1'b0;
        end else if (stop_smp && (!ready || rd)) begin
            rx_data <= shreg;
            ready   <= 1'b1;
            FE      <= ferr_now;
            PE      <= perr_pending;
            OE      <= 1'b0;
        end else if (stop_smp) begin
            OE <= 1'b1;
        end else if (rd && ready) begin
            ready <= 1'b0;
            FE    <= 1'b0;
            PE    <= 1'b0;
            OE    <= 1'b0;
        end
    end

    // busy trails the state by one clock
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            busy <= 1'b0;
        else
            busy <= (state != IDLE);
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at BAUD_DIV=4 (64 clk per bit),
// 8 data bits, even parity.
module tb_uart_rx_core;

    localparam int BD   = 4;
    localparam int BIT  = 16 * BD;
    localparam int ODD  = 0;
    localparam int FLEN = 11 * BIT;
    // stop-bit mid-sample edge, counted from the clk after the start edge
    localparam int DONE = 3 + 4 * (8 + 16 * 10) - 1;

    logic       clk = 1'b0;
    logic       clr;
    logic       rxd;
    logic       rd;
    logic [7:0] rx_data;
    logic       ready, FE, PE, OE, busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_data;
    logic       m_ready, m_fe, m_pe, m_oe;

    uart_rx_core #(
        .BAUD_DIV(BD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(ODD)
    ) dut (
        .clk(clk), .clr(clr), .rxd(rxd), .rd(rd),
        .rx_data(rx_data), .ready(ready), .FE(FE), .PE(PE),
        .OE(OE), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       flip;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip,
                              input logic stop, input logic rd_hit,
                              input int tail_low);
        logic [10:0] b;
        logic        par;
        par = (^d) ^ 1'(ODD) ^ flip;
        b   = {stop, par, d, 1'b0};
        @(negedge clk);
        rxd = 1'b0;
        rd  = 1'b0;
        for (int c = 1; c < FLEN; c++) begin
            @(negedge clk);
            rxd = b[c/BIT];
            rd  = rd_hit && (c == DONE);
        end
        @(negedge clk);
        rd  = 1'b0;
        rxd = (tail_low > 0) ? 1'b0 : 1'b1;
        repeat (tail_low) @(negedge clk);
        if (tail_low == 0)
            repeat (16) @(negedge clk);
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       flip, stop, dord, par;

        vecs[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
        vecs[2] = '{8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};

        clr = 1'b1;
        rxd = 1'b1;
        rd  = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_flags", {FE, PE, OE, busy}, 0);
        clr = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].flip, vecs[i].stop, 1'b0, 0);
            chk("vec_ready", ready, 1);
            chk("vec_data", rx_data, vecs[i].exp_data);
            chk("vec_pe", PE, vecs[i].exp_pe);
            chk("vec_fe", FE, vecs[i].exp_fe);
            chk("vec_oe", OE, 0);
            pulse_rd();
            chk("vec_rd_clr", {ready, FE, PE, OE}, 0);
            chk("vec_rd_hold", rx_data, vecs[i].exp_data);
        end

        // short low glitch on an idle line
        @(negedge clk);
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy_hi", busy, 1);
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_flags", {ready, FE, PE, OE}, 0);

        // stop bit low followed by a long break
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 200);
        chk("brk_fe", FE, 1);
        chk("brk_data", rx_data, 8'h0F);
        chk("brk_busy", busy, 1);
        pulse_rd();
        repeat (64) @(negedge clk);
        chk("brk_busy_hold", busy, 1);
        chk("brk_ready_clr", ready, 0);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        chk("brk_busy_lo", busy, 0);
        repeat (800) @(negedge clk);
        chk("brk_no_frame", ready, 0);

        // overrun, then rd coinciding with completion
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 0);
        chk("oe_data", rx_data, 8'h11);
        chk("oe_flag", OE, 1);
        chk("oe_ready", ready, 1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 0);
        chk("rdhit_data", rx_data, 8'h22);
        chk("rdhit_ready", ready, 1);
        chk("rdhit_oe", OE, 0);

        // clr asserted in the middle of data bit 4
        begin
            logic [10:0] b;
            b = {1'b1, ^8'hC3, 8'hC3, 1'b0};
            @(negedge clk);
            rxd = 1'b0;
            for (int c = 1; c < 5 * BIT + BIT / 2; c++) begin
                @(negedge clk);
                rxd = b[c/BIT];
            end
            #2 clr = 1'b1;
            #1;
            chk("clr_data", rx_data, 0);
            chk("clr_flags", {ready, FE, PE, OE, busy}, 0);
            @(negedge clk);
            clr = 1'b0;
            rxd = 1'b1;
            repeat (20) @(negedge clk);
            chk("clr_idle", {ready, busy}, 0);
        end
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0);
        chk("post_clr_data", rx_data, 8'h5A);
        chk("post_clr_flags", {ready, FE, PE, OE}, 4'b1000);
        pulse_rd();

        m_ready = 1'b0;
        m_data  = 8'h5A;
        m_fe    = 1'b0;
        m_pe    = 1'b0;
        m_oe    = 1'b0;
        for (int k = 0; k < 12; k++) begin
            d    = 8'($urandom);
            flip = ($urandom_range(3) == 0);
            stop = ($urandom_range(4) != 0);
            dord = 1'($urandom_range(1));
            par  = (^d) ^ 1'(ODD) ^ flip;
            send_frame(d, flip, stop, 1'b0, 0);
            if (m_ready) begin
                m_oe = 1'b1;
            end else begin
                m_ready = 1'b1;
                m_data  = d;
                m_fe    = !stop;
                m_pe    = (^d) ^ par ^ 1'(ODD);
                m_oe    = 1'b0;
            end
            chk("rnd_ready", ready, m_ready);
            chk("rnd_data", rx_data, m_data);
            chk("rnd_fe", FE, m_fe);
            chk("rnd_pe", PE, m_pe);
            chk("rnd_oe", OE, m_oe);
            if (dord) begin
                pulse_rd();
                m_ready = 1'b0;
                m_fe    = 1'b0;
                m_pe    = 1'b0;
                m_oe    = 1'b0;
                chk("rnd_rd", {ready, FE, PE, OE},
                    {m_ready, m_fe, m_pe, m_oe});
                chk("rnd_rd_data", rx_data, m_data);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receive front end of the UART. It oversamples the line at 16x the baud rate, validates the start bit, shifts in data LSB first, and checks the optional parity bit and the stop bit. It presents the received byte with a ready flag plus error flags (FE, PE, OE) on the rx side of uart_if. The monitor and the host logic consume these outputs and acknowledge each byte with rd.

Parameters:
BAUD_DIV, 27, clk cycles per oversample tick (clk_freq / (16*baud)); minimum 2
DATA_BITS, 8, data bits per frame (5..8)
PARITY_EN, 1, 1 = parity bit present between data and stop
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
clk  in  1  system clock, all state on rising edge
clr  in  1  reset, asynchronous, active-high
rxd  in  1  serial line, idle high, asynchronous to clk
rd  in  1  consumer acknowledge, 1-cycle pulse, clears ready/FE/PE/OE
rx_data  out  DATA_BITS  last accepted byte
ready  out  1  receive data register full
FE  out  1  framing error (stop bit sampled 0)
PE  out  1  parity error
OE  out  1  overrun (frame completed while ready=1)
busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset (clr=1, async): rx_data=0, ready=0, FE=0, PE=0, OE=0, busy=0. Sync flops=1, counters=0, state=IDLE. A clr mid-frame aborts the frame with no flag update.
- rxd passes through a 2-flop synchronizer (rxs). All decisions use rxs, so input-to-rxs latency is 2 clk.
- Tick generator: counter runs 0..BAUD_DIV-1 and asserts tick for one clk at BAUD_DIV-1. It is free-running and is cleared on entry to START.
- sample_cnt (4 bit) counts ticks within a bit. It is cleared on every state transition.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: rxs=0 -> START.
- START: on the 8th tick (mid-bit), rxs=0 -> DATA. rxs=1 -> IDLE (false start, no flags).
- DATA: sample rxs on every 16th tick and shift into bit DATA_BITS-1 (LSB first). After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY: on the 16th tick, compute the XOR of the data bits with the sampled bit, then XOR with PARITY_ODD. A nonzero result sets perr_pending.
- STOP: on the 16th tick, complete the frame.
  - rxs=1 -> IDLE.
  - rxs=0 -> set ferr_pending, go to WAIT_HIGH.
- WAIT_HIGH: stays until rxs=1, then goes to IDLE. This prevents a break condition from retriggering START.
- Frame completion, in the same cycle as the stop sample:
  - ready=0 (or rd asserted in the same cycle): rx_data <= shift reg, ready<=1, FE<=ferr_pending, PE<=perr_pending, OE<=0.
  - ready=1 and no rd: rx_data, FE and PE are unchanged, OE<=1, and the new byte is dropped.
- rd with no completion in that cycle: ready, FE, PE and OE clear on the next edge; rx_data holds.
- rd with ready=0: no effect.
- Simultaneous rd and completion: completion wins. The new data loads and ready stays 1.
- busy is registered: 1 from the cycle after leaving IDLE until the cycle after returning to IDLE.
- Full frame length = (1 + DATA_BITS + PARITY_EN + 1) * 16 * BAUD_DIV clk, minus the half start bit. ready rises at most 1 clk after the stop-bit mid-sample.
- The pending error flags clear on entry to START.

Test Plan:
- BAUD_DIV=4 (bit = 64 clk). Send 0x55 with even parity bit 0 and stop 1 -> ready=1, rx_data=8'h55, FE=0, PE=0, OE=0. Pulse rd -> ready=0 on the next edge.
- Send 0xA3 with the parity bit inverted (1 instead of 0) -> ready=1, rx_data=8'hA3, PE=1, FE=0.
- Send 0x0F with stop=0, hold rxd low 200 clk, then high -> FE=1, busy stays 1 until rxd is high, and no second frame is received.
- Drive a 20-clk low glitch on idle rxd -> no ready, no flags, busy returns to 0 by mid-start (about 32 clk).
- Send 0x11, then 0x22, with no rd -> rx_data=8'h11, OE=1. Repeat with rd pulsed in the completion cycle of 0x22 -> rx_data=8'h22, ready=1, OE=0.
- Assert clr during data bit 4 of a frame -> all outputs 0 immediately and state returns to IDLE. The next clean 0x5A is received correctly.
